// File: rtl/stump_mem_arbiter_pkg.sv
// Shared types and helpers for the Stump memory-port arbiter.
package stump_mem_arbiter_pkg;

    // Arbiter FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CORE = 2'b01,
        ARB_DMA  = 2'b10
    } arb_state_e;

    localparam int unsigned ARB_ADDR_W_DEF = 16;
    localparam int unsigned ARB_DATA_W_DEF = 16;

    // Number of bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 31) && ((32'd1 << w) <= max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stump_mem_arbiter_if.sv
// Bundle of core, DMA and memory-side signals around the arbiter.
// master: requesters and memory model; slave: the arbiter itself.
interface stump_mem_arbiter_if
    import stump_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W_DEF,
    parameter int unsigned DATA_W = ARB_DATA_W_DEF
);
    // core side
    logic              core_req;
    logic              core_wen;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ready;
    // DMA/debug side
    logic              dma_req;
    logic              dma_wen;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    // memory side
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output core_req, core_wen, core_addr, core_wdata,
        input  core_rdata, core_ready,
        output dma_req, dma_wen, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  core_req, core_wen, core_addr, core_wdata,
        output core_rdata, core_ready,
        input  dma_req, dma_wen, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/stump_wait_counter.sv
// Loadable down-counter with a zero flag; paces memory wait states.
module stump_wait_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stump_mem_arbiter.sv
// Shares the Stump memory port between the core and a DMA/debug requester.
// Each access lasts WAIT_STATES+1 cycles; arbitration happens in IDLE and on
// the final cycle of an access so back-to-back grants have no bubble.
module stump_mem_arbiter
    import stump_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned CORE_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    stump_mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W    = cnt_width(WAIT_STATES);
    localparam int unsigned STREAK_W = cnt_width(CORE_STREAK);
    localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'(WAIT_STATES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CORE_STREAK);

    arb_state_e          state_q;
    logic                op_q;
    logic                ren_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    logic cnt_zero;
    logic in_acc;
    logic arb_point;
    logic grant_dma;
    logic grant_core;
    logic core_final;
    logic dma_final;
    logic cnt_load;
    logic cnt_dec;

    // Arbitration decision and final-cycle decode from registered state.
    always_comb begin
        in_acc     = (state_q != ARB_IDLE);
        arb_point  = !in_acc || cnt_zero;
        grant_dma  = bus.dma_req && (!bus.core_req || (streak_q == STREAK_MAX));
        grant_core = bus.core_req && !grant_dma;
        core_final = (state_q == ARB_CORE) && cnt_zero;
        dma_final  = (state_q == ARB_DMA) && cnt_zero;
        cnt_load   = arb_point && (grant_dma || grant_core);
        cnt_dec    = in_acc && !cnt_zero;
    end

    // Streak of consecutive core grants while DMA waits; saturating.
    always_comb begin
        streak_d = streak_q;
        if (!bus.dma_req) begin
            streak_d = '0;
        end else if (arb_point && grant_dma) begin
            streak_d = '0;
        end else if (arb_point && grant_core && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    stump_wait_counter #(
        .W (CNT_W)
    ) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Arbiter FSM: registers winner's request and drives the memory strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            op_q        <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dma_rdata_q <= '0;
            streak_q    <= '0;
        end else begin
            streak_q <= streak_d;
            if (dma_final && !op_q) begin
                dma_rdata_q <= bus.mem_rdata;
            end
            if (arb_point) begin
                if (grant_dma) begin
                    state_q     <= ARB_DMA;
                    mem_addr_q  <= bus.dma_addr;
                    mem_wdata_q <= bus.dma_wdata;
                    op_q        <= bus.dma_wen;
                    ren_q       <= !bus.dma_wen;
                    wen_q       <= bus.dma_wen;
                end else if (grant_core) begin
                    state_q     <= ARB_CORE;
                    mem_addr_q  <= bus.core_addr;
                    mem_wdata_q <= bus.core_wdata;
                    op_q        <= bus.core_wen;
                    ren_q       <= !bus.core_wen;
                    wen_q       <= bus.core_wen;
                end else begin
                    state_q <= ARB_IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_ren    = ren_q;
    assign bus.mem_wen    = wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_ready = core_final;
    assign bus.core_rdata = core_final ? bus.mem_rdata : '0;
    assign bus.dma_ack    = dma_final;
    assign bus.dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Directed self-checking bench for stump_mem_arbiter (WAIT_STATES=1 and 0).
module tb_stump_mem_arbiter;
    import stump_mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

    stump_mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .WAIT_STATES (1),
        .CORE_STREAK (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    stump_mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .WAIT_STATES (0),
        .CORE_STREAK (4)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.core_req = 0; bus.core_wen = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.dma_req  = 0; bus.dma_wen  = 0; bus.dma_addr  = '0; bus.dma_wdata  = '0;
        bus.mem_rdata = '0;
        bus0.core_req = 0; bus0.core_wen = 0; bus0.core_addr = '0; bus0.core_wdata = '0;
        bus0.dma_req  = 0; bus0.dma_wen  = 0; bus0.dma_addr  = '0; bus0.dma_wdata  = '0;
        bus0.mem_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_ren",    32'(bus.mem_ren),    32'd0);
        check("rst_wen",    32'(bus.mem_wen),    32'd0);
        check("rst_ready",  32'(bus.core_ready), 32'd0);
        check("rst_ack",    32'(bus.dma_ack),    32'd0);
        check("rst_addr",   32'(bus.mem_addr),   32'h0);
        check("rst_wdata",  32'(bus.mem_wdata),  32'h0);
        check("rst_drdata", 32'(bus.dma_rdata),  32'h0);
        check("rst_state",  32'(dut.state_q),    32'(ARB_IDLE));
        rst_n = 1'b1;
        tick();

        // 1. Reset in the wait cycle of a core read
        bus.core_req = 1; bus.core_wen = 0; bus.core_addr = 16'h0044;
        tick();
        check("t1_ren_grant",  32'(bus.mem_ren),    32'd1);
        check("t1_ready_wait", 32'(bus.core_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t1_ren_async",  32'(bus.mem_ren),    32'd0);
        check("t1_ready_rst",  32'(bus.core_ready), 32'd0);
        bus.core_req = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_state_idle", 32'(dut.state_q),    32'(ARB_IDLE));
        check("t1_ready_post", 32'(bus.core_ready), 32'd0);
        check("t1_ren_post",   32'(bus.mem_ren),    32'd0);
        tick();
        check("t1_ready_post2", 32'(bus.core_ready), 32'd0);

        // 2. Core read alone
        bus.core_req = 1; bus.core_wen = 0; bus.core_addr = 16'h0010;
        bus.mem_rdata = 16'hBEEF;
        tick();
        check("t2_ren_c1",   32'(bus.mem_ren),    32'd1);
        check("t2_addr",     32'(bus.mem_addr),   32'h0010);
        check("t2_ready_c1", 32'(bus.core_ready), 32'd0);
        check("t2_rdata_c1", 32'(bus.core_rdata), 32'h0);
        tick();
        check("t2_ren_c2",   32'(bus.mem_ren),    32'd1);
        check("t2_ready_c2", 32'(bus.core_ready), 32'd1);
        check("t2_rdata_c2", 32'(bus.core_rdata), 32'hBEEF);
        bus.core_req = 0;
        tick();
        check("t2_ren_end",   32'(bus.mem_ren),    32'd0);
        check("t2_ready_end", 32'(bus.core_ready), 32'd0);
        check("t2_rdata_end", 32'(bus.core_rdata), 32'h0);

        // 3. DMA write alone
        bus.dma_req = 1; bus.dma_wen = 1; bus.dma_addr = 16'h00FF; bus.dma_wdata = 16'h1234;
        tick();
        check("t3_wen_c1",   32'(bus.mem_wen),   32'd1);
        check("t3_ren_c1",   32'(bus.mem_ren),   32'd0);
        check("t3_addr",     32'(bus.mem_addr),  32'h00FF);
        check("t3_wdata",    32'(bus.mem_wdata), 32'h1234);
        check("t3_ack_c1",   32'(bus.dma_ack),   32'd0);
        tick();
        check("t3_wen_c2",   32'(bus.mem_wen),   32'd1);
        check("t3_ack_c2",   32'(bus.dma_ack),   32'd1);
        bus.dma_req = 0;
        tick();
        check("t3_wen_end",  32'(bus.mem_wen),   32'd0);
        check("t3_ack_end",  32'(bus.dma_ack),   32'd0);

        // 4. Simultaneous requests from IDLE: core first, then DMA
        bus.core_req = 1; bus.core_wen = 0; bus.core_addr = 16'h0030;
        bus.dma_req  = 1; bus.dma_wen  = 0; bus.dma_addr  = 16'h0040;
        bus.mem_rdata = 16'h1111;
        tick();
        check("t4_core_addr", 32'(bus.mem_addr), 32'h0030);
        check("t4_streak1",   32'(dut.streak_q), 32'd1);
        tick();
        check("t4_core_ready", 32'(bus.core_ready), 32'd1);
        check("t4_no_ack",     32'(bus.dma_ack),    32'd0);
        bus.core_req = 0;
        tick();
        check("t4_dma_addr",  32'(bus.mem_addr), 32'h0040);
        check("t4_dma_ren",   32'(bus.mem_ren),  32'd1);
        check("t4_streak0",   32'(dut.streak_q), 32'd0);
        bus.mem_rdata = 16'h2222;
        tick();
        check("t4_dma_ack",   32'(bus.dma_ack),  32'd1);
        bus.dma_req = 0;
        tick();
        check("t4_ack_end",   32'(bus.dma_ack),   32'd0);
        check("t4_drdata",    32'(bus.dma_rdata), 32'h2222);
        check("t4_ren_end",   32'(bus.mem_ren),   32'd0);

        // 5. Streak limit: 4 core accesses, 1 DMA, core resumes
        bus.core_req = 1; bus.core_wen = 0; bus.core_addr = 16'h0100;
        bus.dma_req  = 1; bus.dma_wen  = 0; bus.dma_addr  = 16'h0200;
        for (int a = 0; a < 7; a++) begin
            tick();
            check($sformatf("t5_addr_%0d", a), 32'(bus.mem_addr),
                  (a == 4) ? 32'h0200 : 32'h0100);
            if (a == 4) check("t5_streak_after_dma", 32'(dut.streak_q), 32'd0);
            tick();
            check($sformatf("t5_ready_%0d", a), 32'(bus.core_ready), (a == 4) ? 32'd0 : 32'd1);
            check($sformatf("t5_ack_%0d", a),   32'(bus.dma_ack),    (a == 4) ? 32'd1 : 32'd0);
            if (a == 3) check("t5_streak_sat", 32'(dut.streak_q), 32'd4);
            if (a == 4) bus.dma_req = 0;
        end
        bus.core_req = 0;
        tick();
        check("t5_idle_ren", 32'(bus.mem_ren), 32'd0);

        // 6. DMA read data held through a following core write
        bus.dma_req = 1; bus.dma_wen = 0; bus.dma_addr = 16'h0020;
        bus.mem_rdata = 16'h5A5A;
        tick();
        tick();
        check("t6_ack", 32'(bus.dma_ack), 32'd1);
        bus.dma_req = 0;
        bus.core_req = 1; bus.core_wen = 1; bus.core_addr = 16'h0021; bus.core_wdata = 16'h9999;
        tick();
        check("t6_drdata_c1", 32'(bus.dma_rdata), 32'h5A5A);
        check("t6_core_wen",  32'(bus.mem_wen),   32'd1);
        check("t6_core_addr", 32'(bus.mem_addr),  32'h0021);
        check("t6_core_wd",   32'(bus.mem_wdata), 32'h9999);
        bus.mem_rdata = 16'hDEAD;
        tick();
        check("t6_core_ready", 32'(bus.core_ready), 32'd1);
        check("t6_drdata_c2",  32'(bus.dma_rdata),  32'h5A5A);
        bus.core_req = 0;
        tick();
        check("t6_drdata_idle", 32'(bus.dma_rdata), 32'h5A5A);
        bus.dma_req = 1; bus.dma_wen = 0; bus.dma_addr = 16'h0022;
        tick();
        tick();
        bus.dma_req = 0;
        tick();
        check("t6_drdata_new", 32'(bus.dma_rdata), 32'hDEAD);

        // WAIT_STATES=0 instance: single-cycle accesses
        bus0.core_req = 1; bus0.core_wen = 0; bus0.core_addr = 16'h0050;
        bus0.mem_rdata = 16'h7777;
        tick();
        check("w0_ren",   32'(bus0.mem_ren),    32'd1);
        check("w0_ready", 32'(bus0.core_ready), 32'd1);
        check("w0_rdata", 32'(bus0.core_rdata), 32'h7777);
        bus0.core_addr = 16'h0051;
        tick();
        check("w0_b2b_addr",  32'(bus0.mem_addr),   32'h0051);
        check("w0_b2b_ready", 32'(bus0.core_ready), 32'd1);
        bus0.core_req = 0;
        bus0.dma_req = 1; bus0.dma_wen = 1; bus0.dma_addr = 16'h0060; bus0.dma_wdata = 16'hABCD;
        tick();
        check("w0_dma_wen", 32'(bus0.mem_wen),   32'd1);
        check("w0_dma_ren", 32'(bus0.mem_ren),   32'd0);
        check("w0_dma_ack", 32'(bus0.dma_ack),   32'd1);
        check("w0_dma_wd",  32'(bus0.mem_wdata), 32'hABCD);
        bus0.dma_req = 0;
        tick();
        check("w0_wen_end", 32'(bus0.mem_wen), 32'd0);
        check("w0_ack_end", 32'(bus0.dma_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
